// File: rtl/axi4_master_engine.sv
// AXI4 initiator: turns one command into one INCR burst (AW->W->B or AR->R)
// and reports a single completion pulse with the collected response and error flag.
module axi4_master_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  // write-beat source / read-beat sink
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  // completion
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  done_err,
  // AXI4 write address / data / response
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // AXI4 read address / data
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [7:0]              beat_cnt;
  logic                    last_beat;

  assign last_beat = (beat_cnt == len_q);

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid) state_d = cmd_write ? S_AW : S_AR;
      S_AW:   if (AWREADY) state_d = S_W;
      S_W:    if (WVALID && WREADY && WLAST) state_d = S_B;
      S_B:    if (BVALID) state_d = S_DONE;
      S_AR:   if (ARREADY) state_d = S_R;
      // A missing RLAST still ends the burst on the len-th beat.
      S_R:    if (RVALID && (RLAST || last_beat)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) && !ARESET;
  assign AWVALID   = (state_q == S_AW);
  assign ARVALID   = (state_q == S_AR);
  assign BREADY    = (state_q == S_B);
  assign RREADY    = (state_q == S_R);
  assign done      = (state_q == S_DONE);
  // One bubble per W beat: the source is only offered a slot while the W register is empty.
  assign wr_ready  = (state_q == S_W) && !WVALID;
  assign rd_data   = RDATA;
  assign rd_valid  = RVALID && RREADY;

  assign AWADDR = addr_q;
  assign AWLEN  = len_q;
  assign AWSIZE = size_q;
  assign ARADDR = addr_q;
  assign ARLEN  = len_q;
  assign ARSIZE = size_q;

  // Control state: everything whose value is visible while idle is reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
      beat_cnt  <= '0;
      WVALID    <= 1'b0;
      WLAST     <= 1'b0;
      done_resp <= 2'b00;
      done_err  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            beat_cnt  <= '0;
            done_resp <= 2'b00;
            done_err  <= 1'b0;
          end
        end
        S_W: begin
          if (wr_valid && wr_ready) begin
            WLAST  <= last_beat;
            WVALID <= 1'b1;
          end else if (WVALID && WREADY) begin
            WVALID   <= 1'b0;
            beat_cnt <= beat_cnt + 8'd1;
            if (WLAST) WLAST <= 1'b0;
          end
        end
        S_B: begin
          if (BVALID) done_resp <= BRESP;
        end
        S_R: begin
          if (RVALID) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (RRESP != 2'b00) done_resp <= 2'b10;
            if (RLAST != last_beat) done_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge ACLK) begin
    if (state_q == S_IDLE && cmd_valid) begin
      addr_q <= cmd_addr;
      len_q  <= cmd_len;
      size_q <= cmd_size;
    end
    if (wr_valid && wr_ready) WDATA <= wr_data;
  end

endmodule

// File: tb/tb_axi4_master_engine.sv
// Bench for axi4_master_engine: a behavioural AXI4 memory slave plus scoreboards
// for W beats and read data, driven and sampled on the falling clock edge.
module tb_axi4_master_engine;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid;
  logic        done, done_err;
  logic [1:0]  done_resp;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  always #5 ACLK = ~ACLK;

  axi4_master_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } wbeat_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mem [int];
  wbeat_t      exp_w[$];
  logic [31:0] exp_rd[$];

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    wr_data = '0; wr_valid = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
    ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = '0; RDATA = '0;
  endtask

  // Issues one write command and plays the slave side; rst_after >= 0 pulses
  // ARESET once that many + 1 W beats have been accepted.
  task automatic run_write(input logic [15:0] a, input int len, input logic [31:0] base,
                           input int aw_wait, input int w_wait, input logic [1:0] bresp,
                           input int rst_after, output int done_cyc);
    int aw_hold = 0, w_hold = 0, wr_idx = 0, beats = 0, b_hs_cyc = -100;
    bit b_pend = 0, done_seen = 0, hold_ok = 1, busy_ok = 1, aborted = 0, quiet = 1;
    bit prev_stall = 0;
    logic [31:0] prev_wdata = '0;
    logic prev_wlast = 0;
    wbeat_t e;
    done_cyc = -1;
    @(negedge ACLK);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready); end
    cmd_valid = 1; cmd_write = 1; cmd_addr = a; cmd_len = 8'(len); cmd_size = 3'd2;
    for (int cyc = 1; cyc < 400 && !done_seen && !aborted; cyc++) begin
      @(negedge ACLK);
      cmd_valid = 0; AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0; wr_valid = 0;
      if (rst_after >= 0 && beats > rst_after) begin
        ARESET = 1;
        @(negedge ACLK);
        ARESET = 0;
        #1;
        n_cmp++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, done} !== 6'b0) begin
          n_bad++; $display("FAIL rst_valids: got %b want 000000", {AWVALID, WVALID, ARVALID, BREADY, RREADY, done});
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        for (int k = 0; k < 4; k++) begin
          @(negedge ACLK);
          if (done !== 1'b0) quiet = 0;
        end
        n_cmp++;
        if (!quiet) begin n_bad++; $display("FAIL rst_no_done: got done pulse want none"); end
        exp_w.delete();
        aborted = 1;
      end else if (done === 1'b1) begin
        done_seen = 1; done_cyc = cyc;
        n_cmp++;
        if (done_resp !== bresp) begin n_bad++; $display("FAIL wr_done_resp: got %b want %b", done_resp, bresp); end
        n_cmp++;
        if (done_err !== 1'b0) begin n_bad++; $display("FAIL wr_done_err: got %b want 0", done_err); end
        n_cmp++;
        if (beats !== len + 1) begin n_bad++; $display("FAIL wr_beats: got %0d want %0d", beats, len + 1); end
        n_cmp++;
        if (cyc !== b_hs_cyc + 1) begin n_bad++; $display("FAIL wr_done_timing: got cyc %0d want %0d", cyc, b_hs_cyc + 1); end
      end else begin
        if (cmd_ready !== 1'b0) busy_ok = 0;
        if (AWVALID) begin
          if (AWADDR !== a || AWLEN !== 8'(len) || AWSIZE !== 3'd2) hold_ok = 0;
          if (aw_hold >= aw_wait) AWREADY = 1;
          else aw_hold++;
        end
        if (prev_stall && (WVALID !== 1'b1 || WDATA !== prev_wdata || WLAST !== prev_wlast)) hold_ok = 0;
        prev_stall = 0;
        if (b_pend) begin
          BVALID = 1; BRESP = bresp;
          if (BREADY) begin b_hs_cyc = cyc; b_pend = 0; end
        end
        if (wr_ready && wr_idx <= len) begin
          wr_valid = 1; wr_data = base + 32'(wr_idx);
          e.data = wr_data; e.last = (wr_idx == len);
          exp_w.push_back(e);
          wr_idx++;
        end
        if (WVALID) begin
          if (w_hold >= w_wait) begin
            WREADY = 1; w_hold = 0;
            n_cmp++;
            if (exp_w.size() == 0) begin
              n_bad++; $display("FAIL w_extra_beat: got WDATA %h want no beat", WDATA);
            end else begin
              e = exp_w.pop_front();
              if (WDATA !== e.data || WLAST !== e.last) begin
                n_bad++; $display("FAIL w_beat: got %h/last %b want %h/last %b", WDATA, WLAST, e.data, e.last);
              end
            end
            mem[int'(a) + 4 * beats] = WDATA;
            beats++;
            if (WLAST) b_pend = 1;
          end else begin
            w_hold++; prev_stall = 1; prev_wdata = WDATA; prev_wlast = WLAST;
          end
        end
      end
    end
    idle_inputs();
    if (!aborted) begin
      n_cmp++;
      if (!done_seen) begin n_bad++; $display("FAIL wr_timeout: got no done want done"); end
      n_cmp++;
      if (!hold_ok) begin n_bad++; $display("FAIL wr_hold: got unstable AW/W fields want stable"); end
      n_cmp++;
      if (!busy_ok) begin n_bad++; $display("FAIL wr_busy: got cmd_ready 1 while busy want 0"); end
      @(negedge ACLK);
      n_cmp++;
      if (done !== 1'b0 || cmd_ready !== 1'b1) begin
        n_bad++; $display("FAIL wr_after_done: got done %b cmd_ready %b want 0 1", done, cmd_ready);
      end
    end
  endtask

  // Issues one read command; the slave raises RLAST on beat rlast_at.
  task automatic run_read(input logic [15:0] a, input int len, input int ar_wait, input int rlast_at,
                          input logic [1:0] rresp, input logic [1:0] want_resp, input logic want_err,
                          input int want_pulses, output int done_cyc);
    int ar_hold = 0, r_idx = 0, rd_cnt = 0, last_hs_cyc = -100;
    bit r_active = 0, done_seen = 0, hold_ok = 1, busy_ok = 1;
    logic [31:0] e;
    done_cyc = -1;
    @(negedge ACLK);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rd_cmd_ready: got %b want 1", cmd_ready); end
    cmd_valid = 1; cmd_write = 0; cmd_addr = a; cmd_len = 8'(len); cmd_size = 3'd2;
    for (int cyc = 1; cyc < 400 && !done_seen; cyc++) begin
      @(negedge ACLK);
      cmd_valid = 0; ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = '0; RDATA = '0;
      if (done === 1'b1) begin
        done_seen = 1; done_cyc = cyc;
        n_cmp++;
        if (done_resp !== want_resp) begin n_bad++; $display("FAIL rd_done_resp: got %b want %b", done_resp, want_resp); end
        n_cmp++;
        if (done_err !== want_err) begin n_bad++; $display("FAIL rd_done_err: got %b want %b", done_err, want_err); end
        n_cmp++;
        if (rd_cnt !== want_pulses) begin n_bad++; $display("FAIL rd_pulses: got %0d want %0d", rd_cnt, want_pulses); end
        n_cmp++;
        if (cyc !== last_hs_cyc + 1) begin n_bad++; $display("FAIL rd_done_timing: got cyc %0d want %0d", cyc, last_hs_cyc + 1); end
      end else begin
        if (cmd_ready !== 1'b0) busy_ok = 0;
        if (r_active) begin
          RVALID = 1; RRESP = rresp; RLAST = (r_idx == rlast_at);
          RDATA = mem.exists(int'(a) + 4 * r_idx) ? mem[int'(a) + 4 * r_idx] : 32'hDEAD_BEEF;
        end
        if (ARVALID) begin
          if (ARADDR !== a || ARLEN !== 8'(len) || ARSIZE !== 3'd2) hold_ok = 0;
          if (ar_hold >= ar_wait) begin ARREADY = 1; r_active = 1; end
          else ar_hold++;
        end
        #1;
        if (rd_valid === 1'b1) begin
          rd_cnt++;
          if (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            n_cmp++;
            if (rd_data !== e) begin n_bad++; $display("FAIL rd_data: got %h want %h", rd_data, e); end
          end
        end
        if (RVALID && RREADY) begin
          last_hs_cyc = cyc;
          if (RLAST || r_idx == len) r_active = 0;
          r_idx++;
        end
      end
    end
    idle_inputs();
    n_cmp++;
    if (!done_seen) begin n_bad++; $display("FAIL rd_timeout: got no done want done"); end
    n_cmp++;
    if (exp_rd.size() != 0) begin n_bad++; $display("FAIL rd_missing: got %0d unread beats want 0", exp_rd.size()); end
    exp_rd.delete();
    n_cmp++;
    if (!hold_ok || !busy_ok) begin
      n_bad++; $display("FAIL rd_hold_busy: got hold %b busy %b want 1 1", hold_ok, busy_ok);
    end
    @(negedge ACLK);
    n_cmp++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL rd_after_done: got done %b cmd_ready %b want 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    ARESET = 1;
    idle_inputs();
    repeat (2) @(negedge ACLK);
    outs = {cmd_ready, wr_ready, AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, rd_valid, done, done_err};
    n_cmp++;
    if (outs !== 11'b0) begin n_bad++; $display("FAIL reset_outputs: got %b want 0", outs); end
    n_cmp++;
    if (done_resp !== 2'b00) begin n_bad++; $display("FAIL reset_done_resp: got %b want 00", done_resp); end
    ARESET = 0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_basic();
    int dc;
    run_write(16'h0010, 3, 32'hA0, 0, 0, 2'b00, -1, dc);
  endtask

  task automatic test_read_back();
    int dc;
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'hA0 + 32'(i));
    run_read(16'h0010, 3, 0, 3, 2'b00, 2'b00, 1'b0, 4, dc);
  endtask

  task automatic test_read_slverr();
    int dc;
    run_read(16'h1000, 0, 1, 0, 2'b10, 2'b10, 1'b0, 1, dc);
  endtask

  task automatic test_backpressure();
    int dc;
    run_write(16'h0020, 2, 32'hB0, 5, 3, 2'b00, -1, dc);
    for (int i = 0; i < 3; i++) exp_rd.push_back(32'hB0 + 32'(i));
    run_read(16'h0020, 2, 2, 2, 2'b00, 2'b00, 1'b0, 3, dc);
  endtask

  task automatic test_early_last();
    int dc;
    exp_rd.push_back(32'hA0);
    exp_rd.push_back(32'hA1);
    run_read(16'h0010, 3, 0, 1, 2'b00, 2'b00, 1'b1, 2, dc);
  endtask

  task automatic test_missing_last();
    int dc;
    exp_rd.push_back(32'hA0);
    exp_rd.push_back(32'hA1);
    run_read(16'h0010, 1, 0, 99, 2'b00, 2'b00, 1'b1, 2, dc);
  endtask

  task automatic test_min_latency();
    int dc;
    run_write(16'h0030, 0, 32'hD0, 0, 0, 2'b01, -1, dc);
    n_cmp++;
    if (dc !== 5) begin n_bad++; $display("FAIL min_write_latency: got done at %0d want 5", dc); end
    exp_rd.push_back(32'hD0);
    run_read(16'h0030, 0, 0, 0, 2'b00, 2'b00, 1'b0, 1, dc);
    n_cmp++;
    if (dc !== 3) begin n_bad++; $display("FAIL min_read_latency: got done at %0d want 3", dc); end
  endtask

  task automatic test_mid_reset();
    int dc;
    run_write(16'h0040, 3, 32'hC0, 0, 1, 2'b00, 1, dc);
    run_write(16'h0040, 1, 32'hE0, 0, 0, 2'b00, -1, dc);
    exp_rd.push_back(32'hE0);
    exp_rd.push_back(32'hE1);
    run_read(16'h0040, 1, 0, 1, 2'b00, 2'b00, 1'b0, 2, dc);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_back();
    test_read_slverr();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_min_latency();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
